// File: rtl/mcu_spi_target_if.sv
// Serial pins plus the byte-wide strobe/data bus between mcu_spi_target and its four client blocks.
`timescale 1ns/1ps
interface mcu_spi_target_if;
  logic       spi_ss_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] data_out;
  logic       data_start;
  logic       sys_strobe;
  logic       hid_strobe;
  logic       osd_strobe;
  logic       sdc_strobe;
  logic [7:0] sys_din;
  logic [7:0] hid_din;
  logic [7:0] osd_din;
  logic [7:0] sdc_din;

  modport slave (
    input  spi_ss_n, spi_sck, spi_mosi,
    input  sys_din, hid_din, osd_din, sdc_din,
    output spi_miso, data_out, data_start,
    output sys_strobe, hid_strobe, osd_strobe, sdc_strobe
  );

  modport master (
    output spi_ss_n, spi_sck, spi_mosi,
    output sys_din, hid_din, osd_din, sdc_din,
    input  spi_miso, data_out, data_start,
    input  sys_strobe, hid_strobe, osd_strobe, sdc_strobe
  );
endinterface

// File: rtl/mcu_spi_target.sv
// SPI mode-0 target: the first byte of each frame picks a client, later bytes are strobed to it.
// Define MCU_SPI_SDC_EN to route target ID 3 to the SD-card client; otherwise ID 3 is "none".
`timescale 1ns/1ps
module mcu_spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             reset,
  mcu_spi_target_if.slave bus
);

  typedef enum logic [2:0] {ST_WAIT_SS, ST_IDLE, ST_TGT, ST_CMD, ST_DATA} state_t;
  typedef enum logic [2:0] {SEL_SYS, SEL_HID, SEL_OSD, SEL_SDC, SEL_NONE} sel_t;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic       sck_s, ss_s, mosi_s;
  logic       sck_prev, ss_prev;
  logic       sck_rise, sck_fall, ss_fall;
  logic [2:0] bit_cnt;
  logic [7:0] rx, rx_next, tx, reply;
  logic       byte_done;
  state_t     state, state_next;
  sel_t       sel, sel_next;
  logic       issue, issue_start, strobe_any, load_pend;

  // Sync chains stay unreset so the reset branch of the FSM can see the live SS level.
  always_ff @(posedge clk) begin
    sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.spi_ss_n};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
    sck_prev  <= sck_s;
    ss_prev   <= ss_s;
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign sck_fall  = ~sck_s & sck_prev;
  assign ss_fall   = ~ss_s & ss_prev;
  assign rx_next   = {rx[6:0], mosi_s};
  assign byte_done = sck_rise && !ss_s && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset || ss_s) begin
      bit_cnt <= '0;
    end else if (sck_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
    if (reset) begin
      rx <= '0;
    end else if (sck_rise) begin
      rx <= rx_next;
    end
  end

  function automatic sel_t decode_id(input logic [7:0] id);
    case (id)
      8'd0:    return SEL_SYS;
      8'd1:    return SEL_HID;
      8'd2:    return SEL_OSD;
`ifdef MCU_SPI_SDC_EN
      8'd3:    return SEL_SDC;
`endif
      default: return SEL_NONE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ss_s ? ST_IDLE : ST_WAIT_SS;
      sel   <= SEL_NONE;
    end else begin
      state <= state_next;
      sel   <= sel_next;
    end
  end

  always_comb begin
    state_next  = state;
    sel_next    = sel;
    issue       = 1'b0;
    issue_start = 1'b0;
    case (state)
      ST_WAIT_SS: state_next = state;
      ST_IDLE:    if (ss_fall) state_next = ST_TGT;
      ST_TGT: begin
        if (byte_done) begin
          sel_next   = decode_id(rx_next);
          state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (byte_done) begin
          issue       = 1'b1;
          issue_start = 1'b1;
          state_next  = ST_DATA;
        end
      end
      ST_DATA:    issue = byte_done;
      default:    state_next = ST_IDLE;
    endcase
    if (ss_s) state_next = ST_IDLE;
  end

  always_comb begin
    reply = 8'h00;
    case (sel)
      SEL_SYS: reply = bus.sys_din;
      SEL_HID: reply = bus.hid_din;
      SEL_OSD: reply = bus.osd_din;
`ifdef MCU_SPI_SDC_EN
      SEL_SDC: reply = bus.sdc_din;
`endif
      default: reply = 8'h00;
    endcase
  end

`ifndef MCU_SPI_SDC_EN
  logic unused_sdc_din;
  assign unused_sdc_din = ^bus.sdc_din;
`endif

  assign strobe_any   = bus.sys_strobe | bus.hid_strobe | bus.osd_strobe | bus.sdc_strobe;
  assign bus.spi_miso = tx[7];

  // The falling edge that closes a byte (bit_cnt back at 0) must not shift, or it would eat the freshly loaded reply MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_out   <= 8'h00;
      bus.data_start <= 1'b0;
      bus.sys_strobe <= 1'b0;
      bus.hid_strobe <= 1'b0;
      bus.osd_strobe <= 1'b0;
      bus.sdc_strobe <= 1'b0;
      load_pend      <= 1'b0;
      tx             <= 8'h00;
    end else begin
      bus.sys_strobe <= issue && (sel == SEL_SYS);
      bus.hid_strobe <= issue && (sel == SEL_HID);
      bus.osd_strobe <= issue && (sel == SEL_OSD);
`ifdef MCU_SPI_SDC_EN
      bus.sdc_strobe <= issue && (sel == SEL_SDC);
`else
      bus.sdc_strobe <= 1'b0;
`endif
      bus.data_start <= issue_start && (sel != SEL_NONE);
      if (issue && (sel != SEL_NONE)) bus.data_out <= rx_next;
      load_pend <= strobe_any;
      if (ss_s) begin
        tx <= 8'h00;
      end else if (load_pend) begin
        tx <= reply;
      end else if (sck_fall && (bit_cnt != 3'd0)) begin
        tx <= {tx[6:0], 1'b0};
      end
    end
  end

endmodule
